// File: rtl/icd_pkg.sv
// icd_pkg: shared opcodes, FSM states and status bit positions for the ICD sequencer
package icd_pkg;
  localparam int ADDR_BYTES_DFLT = 3;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_BUS_WR = 4'h1;
  localparam logic [3:0] OP_BUS_RD = 4'h2;
  localparam int ST_BUSY = 7;
  localparam int ST_RDUR = 1;
  localparam int ST_WROV = 0;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_DISCARD} state_e;
endpackage

// File: rtl/icd_bus_port.sv
// icd_bus_port: single-outstanding bus handshake with auto-incrementing address
module icd_bus_port
  import icd_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk6x,
  input  logic              reset,
  input  logic              issue_i,
  input  logic              we_i,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [7:0]        wdata_i,
  input  logic              ack_i,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        wdata_o,
  output logic              busy_o,
  output logic              ack_rd_o
);
  logic req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  assign req_o = req_q;
  assign we_o = we_q;
  assign addr_o = addr_q;
  assign wdata_o = wdata_q;
  assign busy_o = req_q;
  assign ack_rd_o = req_q & ack_i & ~we_q;
  // launch a transaction on issue; retire it on ack and step the address
  always_comb begin
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    if (issue_i) begin
      req_d = 1'b1;
      we_d = we_i;
      wdata_d = wdata_i;
      addr_d = ld_i ? ld_addr_i : addr_q;
    end else if (req_q && ack_i) begin
      req_d = 1'b0;
      addr_d = addr_q + ADDR_W'(1);
    end
  end
  // handshake registers
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: rtl/icd_spi_seq.sv
// icd_spi_seq: parses SPI command bytes into single-byte bus reads/writes and feeds the TX buffer
module icd_spi_seq
  import icd_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int ADDR_BYTES = ADDR_BYTES_DFLT
) (
  input  logic              clk6x,
  input  logic              reset,
  input  logic              spi_csn_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              rx_hdr_en_i,
  input  logic              rx_db_en_i,
  output logic [7:0]        tx_byte_o,
  output logic              tx_en_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [7:0]        bus_rdata_i
);
  localparam int CW = $clog2(ADDR_BYTES + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, ld_q, ld_d, rdp_q, rdp_d, stale_q, stale_d;
  logic rdur_q, rdur_d, wrov_q, wrov_d, rdv_q, rdv_d;
  logic [ADDR_W-1:0] abuf_q, abuf_d;
  logic [7:0] rdat_q, rdat_d, status;
  logic [3:0] op;
  logic busy, ack_rd, issue, iss_we, port_ld, last;
  assign op = rx_byte_i[7:4];
  assign last = (state_q == S_ADDR) && (cnt_q == CW'(ADDR_BYTES - 1));
  assign tx_en_o = ~reset & ((state_q == S_IDLE) | rdv_q);
  assign tx_byte_o = rdv_q ? rdat_q : status;
  // status byte: busy plus the two sticky error flags
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_RDUR] = rdur_q;
    status[ST_WROV] = wrov_q;
  end
  // command FSM: header decode, address assembly, read/write issue and error flags
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    abuf_d = abuf_q;
    ld_d = ld_q;
    rdp_d = rdp_q;
    rdur_d = rdur_q;
    wrov_d = wrov_q;
    issue = 1'b0;
    iss_we = 1'b0;
    stale_d = stale_q & ~(busy & bus_ack_i);
    if (spi_csn_i || rx_hdr_en_i) begin
      rdp_d = 1'b0;
      ld_d = 1'b0;
      cnt_d = '0;
      if (busy && !bus_ack_i) stale_d = 1'b1;
    end
    if (spi_csn_i) state_d = S_IDLE;
    else if (rx_hdr_en_i) begin
      state_d = (op == OP_NOP) ? S_IDLE : (op == OP_BUS_WR || op == OP_BUS_RD) ? S_ADDR : S_DISCARD;
      dir_d = op == OP_BUS_WR;
      if (op == OP_NOP) begin
        rdur_d = 1'b0;
        wrov_d = 1'b0;
      end
    end else if (rx_db_en_i) begin
      if (state_q == S_ADDR) begin
        abuf_d[8*cnt_q +: 8] = rx_byte_i;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = dir_q ? S_WDATA : S_RDATA;
          ld_d = 1'b1;
          rdp_d = ~dir_q;
        end
      end
      if (state_q == S_WDATA) begin
        wrov_d = wrov_q | busy;
        issue = ~busy;
        iss_we = 1'b1;
      end
      if (state_q == S_RDATA) begin
        if (busy || rdp_q) rdur_d = 1'b1;
        else rdp_d = 1'b1;
      end
    end
    if (rdp_d && !busy) begin
      issue = 1'b1;
      iss_we = 1'b0;
      rdp_d = 1'b0;
    end
    port_ld = ld_d;
    if (issue) ld_d = 1'b0;
    rdv_d = ack_rd & ~stale_q & ~spi_csn_i & ~rx_hdr_en_i & (state_q == S_RDATA);
    rdat_d = rdv_d ? bus_rdata_i : rdat_q;
  end
  // sequencer state registers
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      dir_q <= 1'b0;
      abuf_q <= '0;
      ld_q <= 1'b0;
      rdp_q <= 1'b0;
      stale_q <= 1'b0;
      rdur_q <= 1'b0;
      wrov_q <= 1'b0;
      rdv_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      abuf_q <= abuf_d;
      ld_q <= ld_d;
      rdp_q <= rdp_d;
      stale_q <= stale_d;
      rdur_q <= rdur_d;
      wrov_q <= wrov_d;
      rdv_q <= rdv_d;
      rdat_q <= rdat_d;
    end
  end
  icd_bus_port #(.ADDR_W(ADDR_W)) u_port (
    .clk6x(clk6x),
    .reset(reset),
    .issue_i(issue),
    .we_i(iss_we),
    .ld_i(port_ld),
    .ld_addr_i(abuf_d),
    .wdata_i(rx_byte_i),
    .ack_i(bus_ack_i),
    .req_o(bus_req_o),
    .we_o(bus_we_o),
    .addr_o(bus_addr_o),
    .wdata_o(bus_wdata_o),
    .busy_o(busy),
    .ack_rd_o(ack_rd)
  );
endmodule

// File: tb/tb_icd_spi_seq.sv
// tb_icd_spi_seq: vector table plus hand sequences, bus transactions checked through a scoreboard queue
module tb_icd_spi_seq;
  localparam int GAP = 10;
  logic clk6x = 1'b0;
  logic reset, spi_csn_i, rx_hdr_en_i, rx_db_en_i, bus_ack_i;
  logic [7:0] rx_byte_i, bus_rdata_i, tx_byte_o, bus_wdata_o;
  logic tx_en_o, bus_req_o, bus_we_o;
  logic [23:0] bus_addr_o;
  typedef struct { logic we; logic [23:0] addr; logic [7:0] data; } txn_t;
  typedef struct { logic [7:0] hdr; logic [23:0] addr; logic [7:0] dat; logic txn; logic we; logic [7:0] st; } vec_t;
  txn_t exp_bus[$];
  vec_t vecs[7];
  int passed = 0, total = 0;
  int lat = 3, ld_chk = 0, wcnt = 0;
  bit hold_ack = 0, exp_load = 1, seen = 0;
  logic [7:0] ld_val;
  txn_t cur;
  icd_spi_seq dut (
    .clk6x(clk6x), .reset(reset), .spi_csn_i(spi_csn_i), .rx_byte_i(rx_byte_i),
    .rx_hdr_en_i(rx_hdr_en_i), .rx_db_en_i(rx_db_en_i), .tx_byte_o(tx_byte_o), .tx_en_o(tx_en_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );
  always #5 clk6x = ~clk6x;
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk6x);
      #1;
    end
  endtask
  task automatic send(input logic hdr, input logic [7:0] b);
    rx_byte_i = b;
    rx_hdr_en_i = hdr;
    rx_db_en_i = ~hdr;
    cyc(1);
    rx_hdr_en_i = 1'b0;
    rx_db_en_i = 1'b0;
  endtask
  task automatic addr3(input logic [23:0] a);
    for (int k = 0; k < 3; k++) begin
      cyc(GAP);
      send(1'b0, a[8*k +: 8]);
    end
  endtask
  initial begin
    bus_ack_i = 1'b0;
    bus_rdata_i = 8'h00;
    forever begin
      @(posedge clk6x);
      #1;
      bus_ack_i = 1'b0;
      if (ld_chk == 2) begin
        chk("rd_pulse_end", tx_en_o, 1'b0);
        ld_chk = 0;
      end
      if (ld_chk == 1) begin
        chk("rd_load", {tx_en_o, tx_byte_o}, {1'b1, ld_val});
        ld_chk = 2;
      end
      if (!bus_req_o) begin
        seen = 0;
        wcnt = 0;
      end else begin
        if (!seen) begin
          seen = 1;
          if (exp_bus.size() == 0) chk("bus_unexpected", bus_req_o, 1'b0);
          else begin
            cur = exp_bus.pop_front();
            chk("bus_txn", {bus_we_o, bus_addr_o, bus_we_o ? bus_wdata_o : 8'h00},
                {cur.we, cur.addr, cur.we ? cur.data : 8'h00});
          end
        end
        if (!hold_ack) begin
          wcnt++;
          if (wcnt >= lat) begin
            bus_ack_i = 1'b1;
            bus_rdata_i = cur.data;
            if (!cur.we && exp_load) begin
              ld_chk = 1;
              ld_val = cur.data;
            end
          end
        end
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end
  initial begin
    vec_t v;
    bit got;
    vecs[0] = '{8'h10, 24'h001234, 8'hAA, 1'b1, 1'b1, 8'h00};
    vecs[1] = '{8'h1F, 24'hABCDEF, 8'h55, 1'b1, 1'b1, 8'h00};
    vecs[2] = '{8'h20, 24'h000010, 8'h77, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{8'h2C, 24'h800000, 8'hE1, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'h70, 24'h111111, 8'h12, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{8'hF0, 24'h222222, 8'h34, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{8'h3A, 24'h333333, 8'h56, 1'b0, 1'b0, 8'h00};
    reset = 1'b1;
    spi_csn_i = 1'b1;
    rx_byte_i = 8'h00;
    rx_hdr_en_i = 1'b0;
    rx_db_en_i = 1'b0;
    cyc(2);
    chk("reset_outputs", {tx_en_o, tx_byte_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o}, 48'h0);
    reset = 1'b0;
    #1;
    chk("post_reset_status", {tx_en_o, tx_byte_o}, {1'b1, 8'h00});
    cyc(2);
    for (int r = 0; r < 7; r++) begin
      v = vecs[r];
      spi_csn_i = 1'b0;
      cyc(2);
      send(1'b1, v.hdr);
      for (int k = 0; k < 3; k++) begin
        cyc(GAP);
        if (k == 2 && v.txn && !v.we) exp_bus.push_back('{1'b0, v.addr, v.dat});
        send(1'b0, v.addr[8*k +: 8]);
      end
      if (!(v.txn && !v.we)) begin
        cyc(GAP);
        if (v.txn) exp_bus.push_back('{1'b1, v.addr, v.dat});
        send(1'b0, v.dat);
      end
      chk("row_req", bus_req_o, v.txn);
      if (v.txn) chk("row_addr", {bus_we_o, bus_addr_o}, {v.we, v.addr});
      cyc(GAP);
      spi_csn_i = 1'b1;
      cyc(2);
      chk("row_status", {tx_en_o, tx_byte_o}, {1'b1, v.st});
      chk("row_sb_empty", exp_bus.size(), 0);
    end
    spi_csn_i = 1'b0;
    cyc(2);
    send(1'b1, 8'h10);
    addr3(24'h001234);
    cyc(GAP);
    exp_bus.push_back('{1'b1, 24'h001234, 8'hAA});
    chk("wr1_idle", bus_req_o, 1'b0);
    send(1'b0, 8'hAA);
    chk("wr1_req", {bus_req_o, bus_wdata_o}, {1'b1, 8'hAA});
    cyc(GAP);
    exp_bus.push_back('{1'b1, 24'h001235, 8'hBB});
    chk("wr2_idle", bus_req_o, 1'b0);
    send(1'b0, 8'hBB);
    chk("wr2_req", {bus_req_o, bus_addr_o, bus_wdata_o}, {1'b1, 24'h001235, 8'hBB});
    cyc(GAP);
    spi_csn_i = 1'b1;
    cyc(2);
    spi_csn_i = 1'b0;
    cyc(2);
    send(1'b1, 8'h20);
    for (int k = 0; k < 3; k++) begin
      cyc(GAP);
      if (k == 2) exp_bus.push_back('{1'b0, 24'hFFFFFF, 8'h5A});
      send(1'b0, 8'hFF);
    end
    chk("rd_top_req", {bus_req_o, bus_we_o, bus_addr_o}, {1'b1, 1'b0, 24'hFFFFFF});
    cyc(GAP);
    exp_bus.push_back('{1'b0, 24'h000000, 8'hC3});
    send(1'b0, 8'h00);
    chk("rd_wrap_req", {bus_req_o, bus_we_o, bus_addr_o}, {1'b1, 1'b0, 24'h000000});
    cyc(GAP);
    spi_csn_i = 1'b1;
    cyc(2);
    hold_ack = 1;
    spi_csn_i = 1'b0;
    cyc(2);
    send(1'b1, 8'h10);
    addr3(24'h000000);
    cyc(GAP);
    exp_bus.push_back('{1'b1, 24'h000000, 8'h11});
    send(1'b0, 8'h11);
    cyc(2);
    send(1'b0, 8'h22);
    cyc(2);
    chk("ovr_kept", {bus_req_o, bus_addr_o, bus_wdata_o}, {1'b1, 24'h000000, 8'h11});
    hold_ack = 0;
    cyc(GAP);
    spi_csn_i = 1'b1;
    cyc(2);
    chk("ovr_status", {tx_en_o, tx_byte_o}, {1'b1, 8'h01});
    spi_csn_i = 1'b0;
    cyc(2);
    send(1'b1, 8'h00);
    chk("nop_clear", {tx_en_o, tx_byte_o}, {1'b1, 8'h00});
    spi_csn_i = 1'b1;
    cyc(2);
    hold_ack = 1;
    spi_csn_i = 1'b0;
    cyc(2);
    send(1'b1, 8'h20);
    for (int k = 0; k < 3; k++) begin
      cyc(GAP);
      if (k == 2) exp_bus.push_back('{1'b0, 24'h000100, 8'h3C});
      send(1'b0, k == 1 ? 8'h01 : 8'h00);
    end
    cyc(2);
    send(1'b0, 8'h00);
    chk("urun_status", {tx_en_o, tx_byte_o}, {1'b0, 8'h82});
    hold_ack = 0;
    cyc(GAP);
    spi_csn_i = 1'b1;
    cyc(2);
    chk("urun_idle", {tx_en_o, tx_byte_o}, {1'b1, 8'h02});
    spi_csn_i = 1'b0;
    cyc(2);
    send(1'b1, 8'h05);
    chk("nop_clear2", {tx_en_o, tx_byte_o}, {1'b1, 8'h00});
    spi_csn_i = 1'b1;
    cyc(2);
    hold_ack = 1;
    spi_csn_i = 1'b0;
    cyc(2);
    send(1'b1, 8'h20);
    for (int k = 0; k < 3; k++) begin
      cyc(GAP);
      if (k == 2) exp_bus.push_back('{1'b0, 24'h000200, 8'h99});
      send(1'b0, k == 1 ? 8'h02 : 8'h00);
    end
    cyc(2);
    spi_csn_i = 1'b1;
    cyc(2);
    chk("desel_busy", {bus_req_o, tx_en_o, tx_byte_o}, {1'b1, 1'b1, 8'h80});
    exp_load = 0;
    hold_ack = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1);
      got = !bus_req_o;
    end
    chk("desel_ack", {bus_req_o, tx_en_o, tx_byte_o}, {1'b0, 1'b1, 8'h00});
    cyc(3);
    chk("desel_after", {tx_en_o, tx_byte_o}, {1'b1, 8'h00});
    exp_load = 1;
    hold_ack = 1;
    spi_csn_i = 1'b0;
    cyc(2);
    send(1'b1, 8'h10);
    addr3(24'h000000);
    cyc(GAP);
    exp_bus.push_back('{1'b1, 24'h000000, 8'h44});
    send(1'b0, 8'h44);
    chk("rst_req", bus_req_o, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async", {tx_en_o, tx_byte_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o}, 48'h0);
    @(posedge clk6x);
    #3;
    spi_csn_i = 1'b1;
    hold_ack = 0;
    reset = 1'b0;
    #1;
    chk("rst_release", {tx_en_o, tx_byte_o}, {1'b1, 8'h00});
    cyc(3);
    chk("rst_quiet", {bus_req_o, tx_byte_o}, {1'b0, 8'h00});
    chk("sb_empty", exp_bus.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/icd_spi_seq.md
# icd_spi_seq

ICD command sequencer between `spi_slave` and the on-chip bus. It parses the byte stream delivered by the SPI target (header, 24-bit address, data) and turns it into single-byte bus write and read transactions, with auto-incrementing addresses. It keeps the SPI target's TX buffer loaded with either a status byte or read data, ready before the next byte boundary.

## Interface
Parameters:
- `ADDR_W`, 24: bus address width. It must equal 8×`ADDR_BYTES`.
- `ADDR_BYTES`, 3: number of address bytes after the header, sent LSB first.

Ports:
- `clk6x`  in  1  48 MHz system clock. It is the only clock.
- `reset`  in  1  Asynchronous, active-high reset.
- `spi_csn_i`  in  1  Chip select, already synchronised to `clk6x`. High means deselected.
- `rx_byte_i`  in  8  Received byte from `spi_slave`.
- `rx_hdr_en_i`  in  1  One-cycle strobe: the first byte after CSN fell.
- `rx_db_en_i`  in  1  One-cycle strobe: a subsequent byte.
- `tx_byte_o`  out  8  Byte to load into the SPI TX buffer.
- `tx_en_o`  out  1  Load strobe for `tx_byte_o`.
- `bus_req_o`  out  1  Bus request. Held until acknowledged.
- `bus_we_o`  out  1  1 = write, 0 = read. Stable while `bus_req_o` is high.
- `bus_addr_o`  out  ADDR_W  Transaction address.
- `bus_wdata_o`  out  8  Write data.
- `bus_ack_i`  in  1  One-cycle acknowledge. Only meaningful while `bus_req_o` is high.
- `bus_rdata_i`  in  8  Read data. Valid in the cycle `bus_ack_i` is high.

## Operation
- Header opcode is `hdr[7:4]`; `hdr[3:0]` is ignored.
  - 0x0 NOP: clears the sticky status flags.
  - 0x1 BUS_WR: bus write.
  - 0x2 BUS_RD: bus read.
  - Any other value: DISCARD.
- The command FSM has these states: IDLE, ADDR, WDATA, RDATA, DISCARD.
  - IDLE: on `rx_hdr_en_i`, NOP stays in IDLE and clears the flags. BUS_WR/BUS_RD go to ADDR with the address-byte count at 0 and the direction latched. Other opcodes go to DISCARD.
  - ADDR: each `rx_db_en_i` stores the byte into address byte [count], LSB first. After `ADDR_BYTES` bytes the FSM goes to WDATA (write) or RDATA (read). Entering RDATA issues a read at the received address.
  - WDATA: each `rx_db_en_i` issues a write of `rx_byte_i` at the current address.
  - RDATA: each `rx_db_en_i` issues a read at the current address.
  - DISCARD: ignores all bytes.
- Any state goes to IDLE whenever `spi_csn_i` is high. Deselect takes priority over a simultaneous strobe.
- `rx_hdr_en_i` in any state other than IDLE is treated as a fresh header.
- The bus port has at most one outstanding transaction.
  - On ack: the address increments, wrapping from 2^ADDR_W−1 to 0.
  - On a read ack: `tx_byte_o` = `bus_rdata_i`.
- Status byte: bit7 = bus_busy (`bus_req_o`), bit1 = rd_underrun, bit0 = wr_overrun, all other bits 0.
- In IDLE, `tx_byte_o` = status and `tx_en_o` = 1 every cycle.
- Boundary cases:
  - Write strobe while a transaction is pending: the byte is dropped, wr_overrun is set, and the address is unchanged.
  - Read strobe while a read is pending: no new read is issued and rd_underrun is set. The pending data is loaded when its ack arrives.
  - Deselect mid-transaction: `bus_req_o` is held until ack. Read data from that ack is not loaded (status continues).
  - New BUS_RD while a previous transaction is pending: the read is issued in the cycle after that ack.
  - Reset mid-transaction: `bus_req_o` drops immediately.

## Timing
- Reset value of every output is 0.
  - After reset release, the first cycle drives `tx_en_o` = 1 with status 0x00.
- Header strobe at cycle t: the new state applies at t+1.
- Last address byte (read) or a data-byte strobe at cycle t: `bus_req_o`, `bus_we_o`, `bus_addr_o` and `bus_wdata_o` are valid at t+1.
- Ack at cycle a:
  - `bus_req_o` = 0 at a+1.
  - Address increments at a+1.
  - For reads, `tx_en_o` = 1 with the data at a+1. This is a single pulse.
- Read data must be loaded before the next byte boundary.
  - Bus latency must stay below the SPI byte period minus 2 cycles.
  - Otherwise the underrun rule applies.

## Structure
- Package `icd_pkg`:
  - opcode constants OP_NOP/OP_BUS_WR/OP_BUS_RD.
  - FSM state enum.
  - Status bit indices ST_BUSY=7, ST_RDUR=1, ST_WROV=0.
  - Default `ADDR_BYTES`.
- Sub-module `icd_bus_port`: holds the req/ack handshake, address/data registers, address incrementer and the busy flag. The command FSM stays in `icd_spi_seq`.

## Test plan
- Header 0x10, address bytes 0x34,0x12,0x00, data 0xAA,0xBB, ack latency 3 → writes 0xAA@0x001234 and 0xBB@0x001235. `bus_req_o` rises 1 cycle after each strobe.
- Header 0x20, address 0xFF,0xFF,0xFF, bus returns 0x5A then 0xC3 → read at 0xFFFFFF, `tx_en_o` pulse with 0x5A at ack+1; next read at 0x000000 (wrap), 0xC3 loaded.
- BUS_WR with ack delayed past the next data strobe → second byte dropped, status reads 0x01. Header 0x00 then clears the status to 0x00.
- BUS_RD, deselect while a read is pending → `bus_req_o` held until ack, no read-data `tx_en_o`. IDLE status 0x80 until ack, then 0x00.
- Header 0x70 followed by 3 bytes → no bus activity, FSM in DISCARD, IDLE status after CSN high.
- Reset asserted with `bus_req_o` high → all outputs 0 asynchronously. After release, `tx_byte_o` = 0x00 with `tx_en_o` = 1.
